// File: rtl/pipe_skid_register_if.sv
// Valid/ready handshake bundle for pipe_skid_register.
// The slave modport is the register's view; the master modport is the
// view of whatever drives the upstream side and consumes the downstream side.
interface pipe_skid_register_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       count;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  count
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output count
    );
endinterface

// File: rtl/pipe_skid_register.sv
// One-deep skid pipeline register for the MIPS datapath.
// All handshake outputs decode from the state flop only, so downstream
// back-pressure never reaches in_ready combinationally. Flush squashes
// held and arriving words; Rst additionally reloads RESET_VALUE.
module pipe_skid_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Flush,
    pipe_skid_register_if.slave        bus
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;

    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    // Registered-only output decode.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != TWO);
    end

    assign push          = bus.in_valid & in_ready;
    assign pop           = out_valid & bus.out_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.count     = state_q;

    // Next-state and data-path selection; Flush overrides any handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            // Only validity is cleared; data registers keep their contents.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = bus.in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = bus.in_data;
                    end else if (push) begin
                        skid_d  = bus.in_data;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Self-checking bench for pipe_skid_register: directed stimulus pushes
// expected words into a scoreboard queue; a monitor pops and compares on
// every downstream handshake. A second instance with an all-ones reset
// value shares the same stimulus and is checked for its reset value.
module tb_pipe_skid_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];

    pipe_skid_register_if #(.WIDTH(32)) bus_a ();
    pipe_skid_register_if #(.WIDTH(32)) bus_b ();

    pipe_skid_register #(.WIDTH(32), .RESET_VALUE(32'h0000_0000)) dut_a (
        .Clk   (clk),
        .Rst   (rst),
        .Flush (flush),
        .bus   (bus_a)
    );

    pipe_skid_register #(.WIDTH(32), .RESET_VALUE(32'hFFFF_FFFF)) dut_b (
        .Clk   (clk),
        .Rst   (rst),
        .Flush (flush),
        .bus   (bus_b)
    );

    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.out_ready = bus_a.out_ready;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
        bus_a.in_valid  = v;
        bus_a.in_data   = d;
        bus_a.out_ready = rdy;
    endtask

    // Monitor: every downstream handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && !flush && bus_a.out_valid && bus_a.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", bus_a.out_data, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                $display("[TB] pop data=%h expected=%h", bus_a.out_data, e);
                check("pop_data", bus_a.out_data, e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        check("rst_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        check("rst_out_data",  bus_a.out_data, 32'h0);
        check("rst_in_ready",  {31'b0, bus_a.in_ready}, 32'd1);
        check("rst_count",     {30'b0, bus_a.count}, 32'd0);
        check("rst_b_out_data", bus_b.out_data, 32'hFFFF_FFFF);
        step();
        check("rst_no_capture", {30'b0, bus_a.count}, 32'd0);

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, 1'b1);
            exp_q.push_back(i);
            step();
            $display("[TB] push data=%h", i);
            check("stream_out_data", bus_a.out_data, i);
            check("stream_count",    {30'b0, bus_a.count}, 32'd1);
            check("stream_in_ready", {31'b0, bus_a.in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        check("stream_drain_count", {30'b0, bus_a.count}, 32'd0);
        step();
        check("empty_pop_noop_count", {30'b0, bus_a.count}, 32'd0);
        check("empty_holds_data",     bus_a.out_data, 32'h8);

        // Back-pressure into the skid slot.
        drive(1'b1, 32'hA, 1'b0);
        exp_q.push_back(32'hA);
        step();
        drive(1'b1, 32'hB, 1'b0);
        exp_q.push_back(32'hB);
        step();
        check("bp_count",     {30'b0, bus_a.count}, 32'd2);
        check("bp_in_ready",  {31'b0, bus_a.in_ready}, 32'd0);
        check("bp_out_data",  bus_a.out_data, 32'hA);
        drive(1'b1, 32'hC, 1'b0);
        step();
        check("bp_c_rejected", {30'b0, bus_a.count}, 32'd2);
        check("bp_hold_data",  bus_a.out_data, 32'hA);
        drive(1'b1, 32'hC, 1'b1);
        step();
        check("bp_pop_a_data",  bus_a.out_data, 32'hB);
        check("bp_pop_a_count", {30'b0, bus_a.count}, 32'd1);
        exp_q.push_back(32'hC);
        step();
        check("bp_c_data",  bus_a.out_data, 32'hC);
        check("bp_c_count", {30'b0, bus_a.count}, 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        step();
        check("bp_drain_count", {30'b0, bus_a.count}, 32'd0);

        // Simultaneous push and pop while holding one word.
        drive(1'b1, 32'h10, 1'b0);
        exp_q.push_back(32'h10);
        step();
        check("pp_hold_data", bus_a.out_data, 32'h10);
        drive(1'b1, 32'h20, 1'b1);
        exp_q.push_back(32'h20);
        step();
        check("pp_out_data", bus_a.out_data, 32'h20);
        check("pp_count",    {30'b0, bus_a.count}, 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        step();

        // Flush from TWO with an arriving word.
        drive(1'b1, 32'h1, 1'b0);
        step();
        drive(1'b1, 32'h2, 1'b0);
        step();
        check("fl_pre_count", {30'b0, bus_a.count}, 32'd2);
        flush = 1'b1;
        drive(1'b1, 32'h3, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        check("fl_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        check("fl_count",     {30'b0, bus_a.count}, 32'd0);
        check("fl_in_ready",  {31'b0, bus_a.in_ready}, 32'd1);
        drive(1'b1, 32'h4, 1'b1);
        exp_q.push_back(32'h4);
        step();
        check("fl_next_data", bus_a.out_data, 32'h4);
        drive(1'b0, 32'h0, 1'b1);
        step();

        // Flush from ONE while a push is accepted: the word is squashed.
        drive(1'b1, 32'h5, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h6, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        check("fl1_count",    {30'b0, bus_a.count}, 32'd0);
        check("fl1_out_data", bus_a.out_data, 32'h5);
        step();

        // Rst and Flush together while holding data.
        drive(1'b1, 32'h7, 1'b0);
        step();
        drive(1'b1, 32'h9, 1'b0);
        step();
        check("pr_b_holds", bus_b.out_data, 32'h7);
        rst   = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h11, 1'b0);
        step();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        check("pr_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        check("pr_out_data",  bus_a.out_data, 32'h0);
        check("pr_count",     {30'b0, bus_a.count}, 32'd0);
        check("pr_in_ready",  {31'b0, bus_a.in_ready}, 32'd1);
        check("pr_b_out_data", bus_b.out_data, 32'hFFFF_FFFF);
        check("pr_b_count",    {30'b0, bus_b.count}, 32'd0);
        step();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
